mem_loader: RTL and testbench

Byte-serial program/data loader that sits directly upstream of the RISC-V core's data memory load port. It receives a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and drives the core's LD/WD/A inputs with one write pulse per word. It holds the core idle through `cpu_hold` while loading and reports completion or a framing/checksum error.

---
 rtl/mem_loader_if.sv | 28 ++
 rtl/mem_loader.sv | 218 +++++++++++++++++++++
 tb/tb_mem_loader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_loader_if.sv
// Byte-stream sink plus data-memory load-port bus for the mem_loader.
// The slave modport is the loader's view; master is the upstream source / memory side.
interface mem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        LD;
  logic [31:0] WD;
  logic [31:0] A;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output LD,
    output WD,
    output A
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  LD,
    input  WD,
    input  A
  );
endinterface

// File: rtl/mem_loader.sv
// Framed byte-stream loader: assembles little-endian words, writes them through
// the core's load port with one LD pulse each and verifies an XOR checksum.
module mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  mem_loader_if.slave bus,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [15:0] words_loaded
);

  localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_CHK   = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;
  logic [7:0]  chk_q, chk_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] words_q, words_d;
  logic        in_ready_q, in_ready_d;
  logic        ld_q, ld_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] a_q, a_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        xfer_s;
  logic [15:0] n_s;

  function automatic logic [7:0] chk_update(input logic [7:0] chk, input logic [7:0] b);
    return chk ^ b;
  endfunction

  function automatic logic [31:0] insert_byte(input logic [31:0] w, input logic [1:0] lane,
                                              input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (lane)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      2'd3:    r[31:24] = b;
      default: r = w;
    endcase
    return r;
  endfunction

  // Next-state and next-output computation for the whole loader.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    chk_d      = chk_q;
    addr_d     = addr_q;
    words_d    = words_q;
    ld_d       = 1'b0;
    wd_d       = wd_q;
    a_d        = a_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    err_d      = err_q;
    xfer_s     = bus.in_valid & in_ready_q;
    n_s        = {bus.in_data, len_q[7:0]};

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN0;
          cpu_hold_d = 1'b1;
          done_d     = 1'b0;
          err_d      = 1'b0;
          words_d    = 16'd0;
          chk_d      = 8'd0;
          byte_cnt_d = 2'd0;
          addr_d     = BASE_ADDR;
        end else begin
          state_d = state_q;
        end
      end
      S_LEN0: begin
        if (xfer_s) begin
          len_d   = {8'd0, bus.in_data};
          state_d = S_LEN1;
        end else begin
          state_d = S_LEN0;
        end
      end
      S_LEN1: begin
        if (xfer_s) begin
          len_d = n_s;
          if (n_s > MAX_W) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (n_s == 16'd0) begin
            state_d = S_CHK;
          end else begin
            state_d    = S_DATA;
            byte_cnt_d = 2'd0;
          end
        end else begin
          state_d = S_LEN1;
        end
      end
      S_DATA: begin
        if (xfer_s) begin
          word_d     = insert_byte(word_q, byte_cnt_q, bus.in_data);
          chk_d      = chk_update(chk_q, bus.in_data);
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Latch the bus values now so LD, WD and A are all registered in WRITE.
            state_d = S_WRITE;
            ld_d    = 1'b1;
            wd_d    = word_d;
            a_d     = addr_q;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + 32'd4;
        words_d = words_q + 16'd1;
        if (words_d == len_q) begin
          state_d = S_CHK;
        end else begin
          state_d = S_DATA;
        end
      end
      S_CHK: begin
        if (xfer_s) begin
          if (bus.in_data == chk_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end else begin
          state_d = S_CHK;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_LEN0, S_LEN1, S_DATA, S_CHK: in_ready_d = 1'b1;
      default:                       in_ready_d = 1'b0;
    endcase
  end

  // State and registered outputs; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      len_q      <= 16'd0;
      byte_cnt_q <= 2'd0;
      word_q     <= 32'd0;
      chk_q      <= 8'd0;
      addr_q     <= 32'd0;
      words_q    <= 16'd0;
      in_ready_q <= 1'b0;
      ld_q       <= 1'b0;
      wd_q       <= 32'd0;
      a_q        <= 32'd0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      chk_q      <= chk_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
      in_ready_q <= in_ready_d;
      ld_q       <= ld_d;
      wd_q       <= wd_d;
      a_q        <= a_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.LD        = ld_q;
  assign bus.WD        = wd_q;
  assign bus.A         = a_q;
  assign cpu_hold      = cpu_hold_q;
  assign done          = done_q;
  assign err           = err_q;
  assign words_loaded  = words_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed self-checking bench for mem_loader (BASE_ADDR 0x100, MAX_WORDS 4).
module tb_mem_loader;
  logic        clk;
  logic        rst;
  logic        start;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  mem_loader_if bus();

  mem_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  int          checks = 0;
  int          failures = 0;
  int          xfer_cnt = 0;
  logic        last_xfer = 1'b0;
  logic        ld_prev = 1'b0;
  logic [63:0] ld_log [$];
  logic [7:0]  frame [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Count byte transfers as the DUT sees them on each rising edge.
  always @(posedge clk) begin
    if (rst && bus.in_valid && bus.in_ready) begin
      xfer_cnt++;
      last_xfer = 1'b1;
    end else begin
      last_xfer = 1'b0;
    end
  end

  // Every LD must follow a 4th data byte by one cycle, never repeat, and see in_ready low.
  always @(negedge clk) begin
    if (bus.LD === 1'b1) begin
      check("ld_after_4th", {31'd0, last_xfer && (xfer_cnt >= 6) && (((xfer_cnt - 2) % 4) == 0)}, 32'd1);
      check("ld_not_consec", {31'd0, ld_prev}, 32'd0);
      check("ld_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
      ld_log.push_back({bus.A, bus.WD});
    end
    ld_prev = bus.LD;
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    xfer_cnt = 0;
    ld_log.delete();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("xfer_timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      if (gap > 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, gap)) @(negedge clk);
      end
    end
  endtask

  task automatic send_frame(input int gap);
    foreach (frame[i]) send_byte(frame[i], gap);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_ld(input int idx, input logic [31:0] a, input logic [31:0] wd);
    logic [63:0] obs;
    obs = (idx < ld_log.size()) ? ld_log[idx] : {64{1'bx}};
    check("ld_addr", obs[63:32], a);
    check("ld_data", obs[31:0], wd);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    check({tag, "_ld"}, {31'd0, bus.LD}, 32'd0);
    check({tag, "_wd"}, bus.WD, 32'd0);
    check({tag, "_a"}, bus.A, 32'd0);
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_words"}, {16'd0, words_loaded}, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // Two-word frame; XOR of the eight data bytes is 0x2A.
    pulse_start();
    check("start_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("start_in_ready", {31'd0, bus.in_ready}, 32'd1);
    frame = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    send_frame(0);
    check("two_ld_count", ld_log.size(), 32'd2);
    check_ld(0, 32'h0000_0100, 32'h1234_5678);
    check_ld(1, 32'h0000_0104, 32'hDEAD_BEEF);
    check("two_done", {31'd0, done}, 32'd1);
    check("two_err", {31'd0, err}, 32'd0);
    check("two_words", {16'd0, words_loaded}, 32'd2);
    check("two_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    check("two_in_ready", {31'd0, bus.in_ready}, 32'd0);

    // Bad checksum on the same frame, restarted from DONE.
    pulse_start();
    check("bad_done_cleared", {31'd0, done}, 32'd0);
    frame = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
    send_frame(0);
    check("bad_ld_count", ld_log.size(), 32'd2);
    check_ld(0, 32'h0000_0100, 32'h1234_5678);
    check_ld(1, 32'h0000_0104, 32'hDEAD_BEEF);
    check("bad_err", {31'd0, err}, 32'd1);
    check("bad_done", {31'd0, done}, 32'd0);
    check("bad_cpu_hold", {31'd0, cpu_hold}, 32'd1);

    // Length 5 exceeds MAX_WORDS=4.
    pulse_start();
    check("len_err_cleared", {31'd0, err}, 32'd0);
    frame = '{8'h05, 8'h00};
    send_frame(0);
    check("len_err", {31'd0, err}, 32'd1);
    check("len_done", {31'd0, done}, 32'd0);
    check("len_ld_count", ld_log.size(), 32'd0);
    check("len_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("len_in_ready", {31'd0, bus.in_ready}, 32'd0);

    // Zero-length frame, then restart from DONE with a one-word frame.
    pulse_start();
    frame = '{8'h00, 8'h00, 8'h00};
    send_frame(0);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_ld_count", ld_log.size(), 32'd0);
    check("zero_words", {16'd0, words_loaded}, 32'd0);
    pulse_start();
    check("restart_done_cleared", {31'd0, done}, 32'd0);
    check("restart_words_cleared", {16'd0, words_loaded}, 32'd0);
    frame = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_frame(0);
    check("restart_ld_count", ld_log.size(), 32'd1);
    check_ld(0, 32'h0000_0100, 32'h4433_2211);
    check("restart_done", {31'd0, done}, 32'd1);

    // Three words with in_valid held high, then with random gaps; checksum 0x44.
    for (int pass = 0; pass < 2; pass++) begin
      pulse_start();
      frame = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40,
                8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44};
      send_frame(pass * 3);
      check("b2b_xfers", xfer_cnt, 32'd15);
      check("b2b_ld_count", ld_log.size(), 32'd3);
      check_ld(0, 32'h0000_0100, 32'h0403_0201);
      check_ld(1, 32'h0000_0104, 32'h4030_2010);
      check_ld(2, 32'h0000_0108, 32'hDDCC_BBAA);
      check("b2b_done", {31'd0, done}, 32'd1);
      check("b2b_words", {16'd0, words_loaded}, 32'd3);
    end

    // Reset asserted between clock edges after two data bytes.
    pulse_start();
    frame = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    foreach (frame[i]) send_byte(frame[i], 0);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_held");
    rst = 1'b1;
    @(negedge clk);
    check("rst_idle_in_ready", {31'd0, bus.in_ready}, 32'd0);
    pulse_start();
    frame = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_frame(0);
    check("post_rst_ld_count", ld_log.size(), 32'd1);
    check_ld(0, 32'h0000_0100, 32'h4433_2211);
    check("post_rst_done", {31'd0, done}, 32'd1);
    check("post_rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
